// File: rtl/priority_encoder_reg_if.sv
// Request/grant bundle for the registered priority encoder: capture inputs on one
// side, the valid/ready code output plus status on the other.
interface priority_encoder_reg_if #(
    parameter int N = 4
) ();
    localparam int W = $clog2(N);

    logic         en;
    logic [N-1:0] req;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] out_code;
    logic [W:0]   pend_cnt;
    logic         ovf;

    modport master (
        output en, req, out_ready,
        input  out_valid, out_code, pend_cnt, ovf
    );

    modport slave (
        input  en, req, out_ready,
        output out_valid, out_code, pend_cnt, ovf
    );
endinterface

// File: rtl/priority_encoder_reg.sv
// Registered N-to-log2(N) priority encoder: requests accumulate in a pending set and
// the highest-index pending bit is offered as a code held until the consumer accepts it.
module priority_encoder_reg #(
    parameter int N = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    priority_encoder_reg_if.slave bus
);
    localparam int W  = $clog2(N);
    localparam int CW = W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t         state_reg, state_next;
    logic [N-1:0]   pending_reg, pend_next;
    logic [N-1:0]   clr, cap;
    logic [W-1:0]   code_reg, code_next, hi_idx;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic           ovf_reg, ovf_next;
    logic           acc, load;

    assign acc  = (state_reg == HOLD) && bus.out_ready;
    assign load = (state_reg == IDLE) || acc;

    // Only the bit currently being handed over is cleared; a fresh request on the
    // same line in the same cycle re-sets it.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_bits
            assign clr[gi] = acc && (code_reg == W'(gi));
            assign cap[gi] = bus.en && bus.req[gi];
        end
    endgenerate

    assign pend_next = (pending_reg & ~clr) | cap;

    // Ascending scan so the highest set index is the last one written.
    always_comb begin
        hi_idx   = '0;
        cnt_next = '0;
        for (int i = 0; i < N; i++) begin
            if (pend_next[i]) begin
                hi_idx = W'(i);
            end
            cnt_next = cnt_next + CW'(pend_next[i]);
        end
    end

    always_comb begin
        state_next = state_reg;
        code_next  = code_reg;
        if (load) begin
            if (|pend_next) begin
                state_next = HOLD;
                code_next  = hi_idx;
            end else begin
                state_next = IDLE;
            end
        end
        ovf_next = |(cap & pending_reg & ~clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            pending_reg <= '0;
            code_reg    <= '0;
            cnt_reg     <= '0;
            ovf_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pend_next;
            code_reg    <= code_next;
            cnt_reg     <= cnt_next;
            ovf_reg     <= ovf_next;
        end
    end

    always_comb begin
        bus.out_valid = (state_reg == HOLD);
        bus.out_code  = code_reg;
        bus.pend_cnt  = cnt_reg;
        bus.ovf       = ovf_reg;
    end
endmodule

// File: tb/tb_priority_encoder_reg.sv
// Bench for priority_encoder_reg: table of per-cycle vectors with hand-derived
// expected outputs, routed through a scoreboard queue, plus an async reset sequence.
module tb_priority_encoder_reg;
    logic clk;
    logic rst_n;

    priority_encoder_reg_if #(.N(4)) bus ();

    priority_encoder_reg #(.N(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [3:0] req;
        logic       rdy;
        logic       v;
        logic [1:0] code;
        logic [2:0] cnt;
        logic       ovf;
    } vec_t;

    typedef struct {
        int         id;
        logic       v;
        logic [1:0] code;
        logic [2:0] cnt;
        logic       ovf;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string nm, input int act, input int exp_val);
        n_total++;
        if (act == exp_val) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp_val);
    endtask

    function automatic void add(input logic en, input logic [3:0] req, input logic rdy,
                                input logic v, input logic [1:0] code,
                                input logic [2:0] cnt, input logic ovf);
        vec_t t;
        t.en = en; t.req = req; t.rdy = rdy;
        t.v = v; t.code = code; t.cnt = cnt; t.ovf = ovf;
        vecs.push_back(t);
    endfunction

    task automatic check_outputs(input string tag, input logic v, input logic [1:0] code,
                                 input logic [2:0] cnt, input logic ovf);
        chk({tag, " out_valid"}, int'(bus.out_valid), int'(v));
        chk({tag, " out_code"},  int'(bus.out_code),  int'(code));
        chk({tag, " pend_cnt"},  int'(bus.pend_cnt),  int'(cnt));
        chk({tag, " ovf"},       int'(bus.ovf),       int'(ovf));
    endtask

    // Drive one vector, clock it, then pop the scoreboard entry and compare.
    task automatic apply(input int id, input vec_t t);
        exp_t e;
        bus.en        = t.en;
        bus.req       = t.req;
        bus.out_ready = t.rdy;
        e.id = id; e.v = t.v; e.code = t.code; e.cnt = t.cnt; e.ovf = t.ovf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard empty", 0, 1);
        end else begin
            e = sb.pop_front();
            check_outputs($sformatf("v%0d", e.id), e.v, e.code, e.cnt, e.ovf);
            $display("vec %0d en=%0b req=%b rdy=%0b -> valid=%0b code=%0d cnt=%0d ovf=%0b",
                     e.id, t.en, t.req, t.rdy, bus.out_valid, bus.out_code,
                     bus.pend_cnt, bus.ovf);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //   en  req      rdy   v  code cnt ovf
        // single request held five cycles, then accepted
        add(1, 4'b0100, 0,    1, 2, 1, 0);
        for (int k = 0; k < 5; k++) add(1, 4'b0000, 0, 1, 2, 1, 0);
        add(1, 4'b0000, 1,    0, 2, 0, 0);
        // priority drain 3,1,0 without bubbles
        add(1, 4'b1011, 1,    1, 3, 3, 0);
        add(1, 4'b0000, 1,    1, 1, 2, 0);
        add(1, 4'b0000, 1,    1, 0, 1, 0);
        add(1, 4'b0000, 1,    0, 0, 0, 0);
        // held code 1 not displaced by a later higher request
        add(1, 4'b0010, 0,    1, 1, 1, 0);
        add(1, 4'b1000, 0,    1, 1, 2, 0);
        add(1, 4'b0000, 0,    1, 1, 2, 0);
        add(1, 4'b0000, 1,    1, 3, 1, 0);
        add(1, 4'b0000, 1,    0, 3, 0, 0);
        // overflow pulse, then en=0 ignores req but still drains
        add(1, 4'b0001, 0,    1, 0, 1, 0);
        add(1, 4'b0001, 0,    1, 0, 1, 1);
        add(1, 4'b0000, 0,    1, 0, 1, 0);
        add(0, 4'b1000, 0,    1, 0, 1, 0);
        add(0, 4'b1000, 1,    0, 0, 0, 0);
        // re-request on accept is not an overflow
        add(1, 4'b0100, 0,    1, 2, 1, 0);
        add(1, 4'b0100, 1,    1, 2, 1, 0);
        add(1, 4'b0000, 1,    0, 2, 0, 0);
        // overflow on a non-granted bit while the grant is accepted
        add(1, 4'b0011, 0,    1, 1, 2, 0);
        add(1, 4'b0001, 1,    1, 0, 1, 1);
        add(1, 4'b0000, 1,    0, 0, 0, 0);
        // all lines pending: pend_cnt reaches N
        add(1, 4'b1111, 0,    1, 3, 4, 0);

        rst_n         = 1'b0;
        bus.en        = 1'b0;
        bus.req       = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_outputs("reset", 0, 0, 0, 0);

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

        // Async reset mid-cycle with all requests asserted, no clock edge in between
        bus.en  = 1'b1;
        bus.req = 4'b1111;
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs("async_rst", 0, 0, 0, 0);
        $display("async reset -> valid=%0b code=%0d cnt=%0d ovf=%0b",
                 bus.out_valid, bus.out_code, bus.pend_cnt, bus.ovf);
        @(posedge clk);
        #1;
        check_outputs("rst_held", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Earlier pending bits must be gone: only bit 0 requested now
        bus.req = 4'b0000;
        @(posedge clk);
        #1;
        begin
            vec_t t;
            t.en = 1; t.req = 4'b0001; t.rdy = 1;
            t.v = 1; t.code = 0; t.cnt = 1; t.ovf = 0;
            // drain what the released-reset edge captured (req=1111) first
            bus.out_ready = 1'b1;
            repeat (4) @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
            check_outputs("post_rst_drain", 0, 0, 0, 0);
            apply(100, t);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
